// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_scheduler
// Description : Round-robin scheduler sharing one serial symmetric-FIR MAC
//               datapath between CHANNELS sample sources, with rounding and
//               optional saturation (macro FIR_SCHED_SAT_EN) of the result.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler #(
    parameter int CHANNELS    = 4,
    parameter int FIR_TAP     = 30,
    parameter int IDATA_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 16,
    parameter int MAC_LAT     = 1,
    localparam int c_half     = FIR_TAP / 2,
    localparam int c_cw       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int c_tw       = (c_half > 1) ? $clog2(c_half) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             req_valid,
    input  logic [CHANNELS*IDATA_WIDTH-1:0] req_data,
    output logic [CHANNELS-1:0]             req_ready,
    output logic                            dp_wr_en,
    output logic [IDATA_WIDTH-1:0]          dp_wr_data,
    output logic [c_cw-1:0]                 dp_chan,
    output logic [c_tw-1:0]                 dp_tap,
    output logic                            dp_mac_en,
    output logic                            dp_mac_clr,
    input  logic [ACC_WIDTH-1:0]            dp_acc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [c_cw-1:0]                 out_chan,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            busy
);

    localparam int c_dw = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [c_tw-1:0]    c_tap_last   = c_tw'(c_half - 1);
    localparam logic [c_dw-1:0]    c_drain_last = c_dw'(MAC_LAT - 1);
    localparam logic [ACC_WIDTH:0] c_round      = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);

    logic [1:0]           r_state;
    logic [c_cw-1:0]      r_rr_ptr;
    logic [c_cw-1:0]      r_chan;
    logic [c_tw-1:0]      r_tap;
    logic [c_dw-1:0]      r_drain;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [c_cw-1:0]      r_out_chan;

    logic [c_cw-1:0]      w_grant;
    logic [c_cw-1:0]      w_idx;
    logic                 w_grant_vld;
    logic [CHANNELS-1:0]  w_req_ready;

    logic signed [ACC_WIDTH:0] w_sum;
    logic signed [ACC_WIDTH:0] w_shifted;
    logic [OUT_WIDTH-1:0]      w_result;

    // Walk the search order from farthest to nearest so the nearest valid wins.
    always_comb begin
        w_grant     = '0;
        w_idx       = '0;
        w_grant_vld = 1'b0;
        for (int i = CHANNELS; i >= 1; i--) begin
            w_idx = c_cw'((int'(r_rr_ptr) + i) % CHANNELS);
            if (req_valid[w_idx]) begin
                w_grant     = w_idx;
                w_grant_vld = 1'b1;
            end
        end
        if (rst || (r_state != S_IDLE)) begin
            w_grant     = '0;
            w_grant_vld = 1'b0;
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_grant_vld) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_sum     = $signed({dp_acc[ACC_WIDTH-1], dp_acc}) + $signed(c_round);
    assign w_shifted = w_sum >>> SHIFT;

`ifdef FIR_SCHED_SAT_EN
    localparam logic signed [ACC_WIDTH:0] c_out_max =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_out_min =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    always_comb begin
        if (w_shifted > c_out_max) begin
            w_result = c_out_max[OUT_WIDTH-1:0];
        end else if (w_shifted < c_out_min) begin
            w_result = c_out_min[OUT_WIDTH-1:0];
        end else begin
            w_result = w_shifted[OUT_WIDTH-1:0];
        end
    end
`else
    // Two's-complement wrap: the upper bits are simply discarded.
    logic w_unused;
    assign w_unused = ^w_shifted[ACC_WIDTH:OUT_WIDTH];
    assign w_result = w_shifted[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= c_cw'(CHANNELS - 1);
            r_chan     <= '0;
            r_tap      <= '0;
            r_drain    <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_chan  <= w_grant;
                        r_tap   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (r_tap == c_tap_last) begin
                        r_tap   <= '0;
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == c_drain_last) begin
                        r_out_data <= w_result;
                        r_out_chan <= r_chan;
                        r_drain    <= '0;
                        r_state    <= S_OUT;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_rr_ptr <= r_chan;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign dp_wr_en   = w_grant_vld;
    assign dp_wr_data = w_grant_vld ? req_data[w_grant*IDATA_WIDTH +: IDATA_WIDTH] : '0;
    assign dp_chan    = (r_state == S_IDLE) ? w_grant : r_chan;
    assign dp_tap     = r_tap;
    assign dp_mac_en  = (r_state == S_MAC);
    assign dp_mac_clr = (r_state == S_MAC) && (r_tap == '0);
    assign out_valid  = (r_state == S_OUT);
    assign out_chan   = r_out_chan;
    assign out_data   = r_out_data;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

- Controller that shares one serial symmetric-FIR MAC datapath between `CHANNELS` sample sources.
- Arbitrates incoming samples round-robin and steers the accepted sample into the selected channel's delay line.
- Sequences the half-tap index and MAC clear/enable, then rounds and saturates the accumulator.
- Presents the filtered result with a channel tag on a valid/ready output.

## Interface
Parameters:
- `CHANNELS`, 4: number of requesters (≥2)
- `FIR_TAP`, 30: filter taps (even); `HALF = FIR_TAP/2` MAC cycles per sample
- `IDATA_WIDTH`, 16: sample width
- `ACC_WIDTH`, 32: datapath accumulator width
- `OUT_WIDTH`, 16: output width
- `SHIFT`, 16: right shift applied to accumulator (≥1)
- `MAC_LAT`, 1: cycles from last `dp_mac_en` to `dp_acc` valid (≥1)

Ports (`CW = max(1,$clog2(CHANNELS))`, `TW = max(1,$clog2(HALF))`):
- `clk` in 1: single clock
- `rst` in 1: reset is synchronous and active-high
- `req_valid` in CHANNELS: per-channel sample available
- `req_data` in CHANNELS*IDATA_WIDTH: channel i occupies bits [i*IDATA_WIDTH +: IDATA_WIDTH]
- `req_ready` out CHANNELS: one-hot accept
- `dp_wr_en` out 1: shift `dp_wr_data` into channel `dp_chan` delay line
- `dp_wr_data` out IDATA_WIDTH: accepted sample
- `dp_chan` out CW: channel currently owning the datapath
- `dp_tap` out TW: symmetric-pair index
- `dp_mac_en` out 1: accumulate product for `dp_tap`
- `dp_mac_clr` out 1: this product loads, not adds
- `dp_acc` in ACC_WIDTH: signed accumulator from datapath
- `out_valid` out 1, `out_ready` in 1: result handshake
- `out_chan` out CW: channel of result
- `out_data` out OUT_WIDTH: signed result
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states:
  - IDLE: `rr_ptr` search order `rr_ptr+1, rr_ptr+2, …` modulo CHANNELS. The first valid channel g gets `req_ready[g]=1` (combinational, same cycle), along with `dp_wr_en=1`, `dp_wr_data=req_data[g]` and `dp_chan=g`. Transfer occurs that cycle; next state is MAC. With no valid channel, stay in IDLE with all strobes 0.
  - MAC: HALF cycles, `dp_tap` = 0..HALF-1, `dp_mac_en=1`. `dp_mac_clr=1` only when `dp_tap==0`. After tap HALF-1, go to DRAIN.
  - DRAIN: MAC_LAT cycles, strobes 0. On the last DRAIN cycle, `dp_acc` is sampled, the result computed and registered, and the state goes to OUT.
  - OUT: `out_valid=1` with `out_chan=g`. On `out_valid&&out_ready`, `rr_ptr<=g` and the state goes to IDLE.
- `req_ready` is all-zero outside IDLE; requesters hold their data.
- `dp_chan` holds g from grant through OUT.
- Arithmetic:
  - Sign-extend `dp_acc` to ACC_WIDTH+1 and add `1<<(SHIFT-1)` (round half up).
  - Arithmetic right shift by SHIFT.
  - Clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] (see Configuration).
- Reset:
  - State IDLE, `rr_ptr=CHANNELS-1` (channel 0 first).
  - All outputs 0: `req_ready`, `dp_wr_en`, `dp_wr_data`, `dp_chan`, `dp_tap`, `dp_mac_en`, `dp_mac_clr`, `out_valid`, `out_chan`, `out_data`, `busy`.
- Reset mid-operation abandons the sample: no `out_valid`, no `rr_ptr` update.

## Timing
- Grant cycle t0.
- MAC cycles t1..tHALF.
- DRAIN cycles tHALF+1..tHALF+MAC_LAT.
- `out_valid` is first high at tHALF+MAC_LAT+1. Defaults: t16 is DRAIN, `out_valid` from t17.
- Minimum period per sample is HALF+MAC_LAT+2 cycles (18 by default). The next grant comes in the cycle after the output handshake.
- `out_data` and `out_chan` are registered and stable while `out_valid && !out_ready`.
- A `req_valid` deassertion before grant is permitted; that channel is skipped.

## Configuration
- `FIR_SCHED_SAT_EN` defined: the shifted value saturates to the OUT_WIDTH signed range.
- Not defined: `out_data` is the low OUT_WIDTH bits of the shifted value (two's-complement wrap). No saturation logic is built.

## Test plan
- Channel 0 valid with data 0x0100, others idle:
  - `req_ready=4'b0001` at t0 with `dp_wr_en=1` and `dp_wr_data=0x0100`.
  - `dp_tap` runs 0..14 over t1..t15, with `dp_mac_clr` only at t1.
  - `out_valid` at t17 with `out_chan=0`.
- `dp_acc=0x0001_8000` -> `out_data=2`. `dp_acc=0xFFFE_8000` -> `out_data=0xFFFF` (−1).
- `dp_acc=0x7FFF_FFFF`:
  - `out_data=0x7FFF` with `FIR_SCHED_SAT_EN`, 0x8000 without.
  - `dp_acc=0x8000_0000` -> 0x8000 in both builds.
- All four channels valid continuously with `out_ready=1` -> grants in order 0,1,2,3,0, spaced 18 cycles apart.
- `out_ready` low for 5 cycles in OUT -> `out_valid`, `out_data` and `out_chan` unchanged, `req_ready=0`. The grant goes to the next channel the cycle after `out_ready` rises.
- Assert `rst` during MAC at `dp_tap=7` -> next cycle all outputs 0 and no `out_valid` for that sample. After release, channel 0 is granted first.
